ctrl_bht_predictor: RTL



---
 rtl/ctrl_bht_predictor_pkg.sv | 33 +++
 rtl/ctrl_bht_predictor_sat_counter.sv | 40 ++++
 rtl/ctrl_bht_predictor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ctrl_bht_predictor_pkg.sv
// Shared definitions for the branch predictor: condition bit positions,
// counter initial value and the saturating step used by every counter.
package ctrl_pkg;

    localparam int COND_GT     = 0;
    localparam int COND_LT     = 1;
    localparam int COND_EQ     = 2;
    localparam int COND_CARRY  = 3;
    localparam int COND_UNCOND = 4;
    localparam int COND_W      = 5;
    localparam int FLAG_W      = 4;

    // Weakly-not-taken: just below the taken threshold (01 for a 2-bit counter).
    function automatic logic [31:0] ctr_init(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_step(input logic [31:0] val,
                                             input logic        inc,
                                             input logic [31:0] max_val);
        logic [31:0] res;
        res = val;
        if (inc) begin
            if (val >= max_val) res = val;
            else                res = val + 32'd1;
        end else begin
            if (val == 32'd0)   res = val;
            else                res = val - 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ctrl_bht_predictor_sat_counter.sv
// Generic saturating up/down counter; used both for the history table
// entries and for the performance counters.
module ctrl_sat_counter
    import ctrl_pkg::*;
#(
    parameter int unsigned    W    = 2,
    parameter logic [W-1:0]   INIT = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] value
);

    localparam logic [31:0] MAX_VAL = (W >= 32) ? 32'hFFFF_FFFF
                                                : ((32'd1 << W) - 32'd1);

    logic [W-1:0] value_r;
    logic [W-1:0] next_s;

    // Next value, clamped at both ends.
    always_comb begin
        next_s = W'(sat_step(32'(value_r), inc, MAX_VAL));
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= INIT;
        end else if (en) begin
            value_r <= next_s;
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/ctrl_bht_predictor.sv
// Dynamic branch predictor: predicts jumps in IF/ID from a table of saturating
// counters, resolves them in EX against the flags, and trains the table.
module ctrl_bht_predictor
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pc_IFID,
    input  logic [COND_W-1:0] conds_IFID,
    input  logic              stall,
    input  logic              invalidate_instr,
    input  logic [FLAG_W-1:0] flags_EX,
    output logic              branch_taken,
    output logic              mispredict,
    output logic              redirect_taken,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [PERF_W-1:0] perf_jumps,
    output logic [PERF_W-1:0] perf_mispred
);

    localparam int unsigned      ENTRIES  = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

    logic [CTR_W-1:0]  ctr_s [ENTRIES];
    logic [IDX_W-1:0]  look_idx_s;
    logic              is_jump_s;
    logic              pred_s;
    logic              actual_s;
    logic              mispred_s;
    logic              consume_s;
    logic              train_s;

    logic              trk_valid_r;
    logic [IDX_W-1:0]  trk_idx_r;
    logic [PC_W-1:0]   trk_pc_r;
    logic [COND_W-1:0] trk_conds_r;
    logic              trk_pred_r;

    assign look_idx_s = pc_IFID[IDX_W-1:0];

    // Lookup: reads the counter as it stands this cycle, so a same-cycle
    // training write is not yet visible.
    always_comb begin
        is_jump_s = (|conds_IFID) && !invalidate_instr;
        if (!is_jump_s) begin
            pred_s = 1'b0;
        end else if (conds_IFID[COND_UNCOND]) begin
            pred_s = 1'b1;
        end else begin
            pred_s = ctr_s[look_idx_s][CTR_W-1];
        end
    end

    // Resolution of the tracked jump; flag bits line up with condition bits.
    always_comb begin
        actual_s  = (|(trk_conds_r[COND_CARRY:COND_GT] & flags_EX))
                    | trk_conds_r[COND_UNCOND];
        mispred_s = trk_valid_r && (actual_s != trk_pred_r);
        consume_s = trk_valid_r && !stall;
        train_s   = consume_s && !trk_conds_r[COND_UNCOND]
                    && (|trk_conds_r[COND_CARRY:COND_GT]);
    end

    // IF/ID -> EX tracking; a mispredict kills whatever IF/ID holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_valid_r <= 1'b0;
            trk_idx_r   <= {IDX_W{1'b0}};
            trk_pc_r    <= {PC_W{1'b0}};
            trk_conds_r <= {COND_W{1'b0}};
            trk_pred_r  <= 1'b0;
        end else if (stall) begin
            trk_valid_r <= trk_valid_r;
            trk_idx_r   <= trk_idx_r;
            trk_pc_r    <= trk_pc_r;
            trk_conds_r <= trk_conds_r;
            trk_pred_r  <= trk_pred_r;
        end else begin
            trk_valid_r <= is_jump_s && !mispred_s;
            trk_idx_r   <= look_idx_s;
            trk_pc_r    <= pc_IFID;
            trk_conds_r <= conds_IFID;
            trk_pred_r  <= pred_s;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_tbl
        ctrl_sat_counter #(.W(CTR_W), .INIT(CTR_INIT)) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (train_s && (trk_idx_r == IDX_W'(i))),
            .inc   (actual_s),
            .value (ctr_s[i])
        );
    end

    ctrl_sat_counter #(.W(PERF_W), .INIT({PERF_W{1'b0}})) u_perf_jumps (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (consume_s),
        .inc   (1'b1),
        .value (perf_jumps)
    );

    ctrl_sat_counter #(.W(PERF_W), .INIT({PERF_W{1'b0}})) u_perf_mispred (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (consume_s && mispred_s),
        .inc   (1'b1),
        .value (perf_mispred)
    );

    assign branch_taken   = pred_s;
    assign mispredict     = mispred_s;
    assign redirect_taken = trk_valid_r && actual_s;
    assign redirect_pc    = trk_valid_r ? trk_pc_r : {PC_W{1'b0}};

endmodule
